// File: rtl/mc_control_unit.sv
// -----------------------------------------------------------------------------
// mc_control_unit
// Multicycle sequencing controller for the 16-bit MIPS-style datapath.
// A Moore FSM walks each instruction through FETCH/DECODE/execute/memory/
// write-back states, one state per cycle, and drives every datapath select,
// enable and ALU operation from the current state. Memory states stretch on
// mem_ready, illegal encodings park the FSM in HALT, and retired instructions
// are counted.
//
// Ports
//   clk            rising-edge clock
//   rst_n          asynchronous active-low reset
//   opcode[3:0]    IR[15:12], stable from DECODE onward
//   funct[2:0]     IR[2:0], R-type ALU function
//   zero           ALU zero flag (qualification is done in the datapath)
//   mem_ready      memory completes the current access this cycle
//   pc_write       unconditional PC load
//   pc_write_cond  PC load qualified by zero
//   i_or_d         address mux: 0 = PC, 1 = ALUOut
//   mem_read       memory read strobe
//   mem_write      memory write strobe
//   ir_write       instruction-register load
//   reg_dst        write-register mux: 0 = rt, 1 = rd
//   mem_to_reg     write-data mux: 0 = ALUOut, 1 = MDR
//   reg_write      register-file write
//   alu_src_a      0 = PC, 1 = A
//   alu_src_b[1:0] 00 = B, 01 = constant 1, 10 = sign-extended imm
//   alu_op[2:0]    000 add, 001 sub, 010 and, 011 or, 100 slt
//   pc_src[1:0]    00 = ALU result, 01 = ALUOut, 10 = jump target
//   state[3:0]     current state code (debug)
//   halted         sticky illegal-instruction flag
//   instr_count    retired-instruction counter (wraps)
// -----------------------------------------------------------------------------
module mc_control_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  opcode,
  input  logic [2:0]  funct,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        pc_write,
  output logic        pc_write_cond,
  output logic        i_or_d,
  output logic        mem_read,
  output logic        mem_write,
  output logic        ir_write,
  output logic        reg_dst,
  output logic        mem_to_reg,
  output logic        reg_write,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [2:0]  alu_op,
  output logic [1:0]  pc_src,
  output logic [3:0]  state,
  output logic        halted,
  output logic [15:0] instr_count
);

  // State codes
  localparam logic [3:0] S_FETCH  = 4'd0;
  localparam logic [3:0] S_DECODE = 4'd1;
  localparam logic [3:0] S_EXEC_R = 4'd2;
  localparam logic [3:0] S_EXEC_I = 4'd3;
  localparam logic [3:0] S_ADDR   = 4'd4;
  localparam logic [3:0] S_MEM_RD = 4'd5;
  localparam logic [3:0] S_WB_MEM = 4'd6;
  localparam logic [3:0] S_MEM_WR = 4'd7;
  localparam logic [3:0] S_WB_ALU = 4'd8;
  localparam logic [3:0] S_BRANCH = 4'd9;
  localparam logic [3:0] S_JUMP   = 4'd10;
  localparam logic [3:0] S_HALT   = 4'd11;

  // Opcodes
  localparam logic [3:0] OP_RTYPE = 4'b0000;
  localparam logic [3:0] OP_ADDI  = 4'b0001;
  localparam logic [3:0] OP_LW    = 4'b0010;
  localparam logic [3:0] OP_SW    = 4'b0011;
  localparam logic [3:0] OP_BEQ   = 4'b0100;
  localparam logic [3:0] OP_J     = 4'b0101;

  // Highest legal R-type funct (slt)
  localparam logic [2:0] FUNCT_MAX = 3'b100;

  // ALU operations
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;

  logic [3:0]  state_r;
  logic [3:0]  next_state_s;
  logic        halted_r;
  logic [15:0] instr_count_r;
  logic        retire_s;
  logic        zero_unused_s;

  // Branch qualification by zero happens in the datapath, not here.
  assign zero_unused_s = zero;

  // Next-state decode
  always_comb begin
    next_state_s = S_HALT;
    case (state_r)
      S_FETCH:  next_state_s = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          OP_RTYPE: begin
            if (funct > FUNCT_MAX) begin
              next_state_s = S_HALT;
            end else begin
              next_state_s = S_EXEC_R;
            end
          end
          OP_ADDI:  next_state_s = S_EXEC_I;
          OP_LW:    next_state_s = S_ADDR;
          OP_SW:    next_state_s = S_ADDR;
          OP_BEQ:   next_state_s = S_BRANCH;
          OP_J:     next_state_s = S_JUMP;
          default:  next_state_s = S_HALT;
        endcase
      end
      S_EXEC_R: next_state_s = S_WB_ALU;
      S_EXEC_I: next_state_s = S_WB_ALU;
      // IR is stable here, so anything other than LW/SW cannot occur;
      // treat it as illegal rather than guess.
      S_ADDR: begin
        case (opcode)
          OP_LW:   next_state_s = S_MEM_RD;
          OP_SW:   next_state_s = S_MEM_WR;
          default: next_state_s = S_HALT;
        endcase
      end
      S_MEM_RD: next_state_s = mem_ready ? S_WB_MEM : S_MEM_RD;
      S_WB_MEM: next_state_s = S_FETCH;
      S_MEM_WR: next_state_s = mem_ready ? S_FETCH : S_MEM_WR;
      S_WB_ALU: next_state_s = S_FETCH;
      S_BRANCH: next_state_s = S_FETCH;
      S_JUMP:   next_state_s = S_FETCH;
      S_HALT:   next_state_s = S_HALT;
      default:  next_state_s = S_HALT;
    endcase
  end

  // An instruction retires when its final state hands control back to FETCH.
  always_comb begin
    retire_s = 1'b0;
    case (state_r)
      S_WB_ALU, S_WB_MEM, S_MEM_WR, S_BRANCH, S_JUMP:
        retire_s = (next_state_s == S_FETCH);
      default:
        retire_s = 1'b0;
    endcase
  end

  // State, sticky halt flag and retirement counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= S_FETCH;
      halted_r      <= 1'b0;
      instr_count_r <= 16'h0000;
    end else begin
      state_r <= next_state_s;
      if (next_state_s == S_HALT) begin
        halted_r <= 1'b1;
      end
      if (retire_s) begin
        instr_count_r <= instr_count_r + 16'h0001;
      end
    end
  end

  // Moore output decode; only FETCH's ir_write/pc_write look at mem_ready,
  // and they are also held off while reset is asserted.
  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = ALU_ADD;
    pc_src        = 2'b00;
    case (state_r)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ready & rst_n;
        pc_write  = mem_ready & rst_n;
      end
      S_DECODE: begin
        alu_src_b = 2'b10;
      end
      S_EXEC_R: begin
        alu_src_a = 1'b1;
        alu_op    = funct;
      end
      S_EXEC_I, S_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_MEM_RD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
      end
      S_WB_MEM: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_MEM_WR: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
      end
      S_WB_ALU: begin
        reg_write = 1'b1;
        reg_dst   = (opcode == OP_RTYPE);
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = ALU_SUB;
        pc_write_cond = 1'b1;
        pc_src        = 2'b01;
      end
      S_JUMP: begin
        pc_write = 1'b1;
        pc_src   = 2'b10;
      end
      default: begin
        pc_write = 1'b0;
      end
    endcase
  end

  assign state       = state_r;
  assign halted      = halted_r;
  assign instr_count = instr_count_r;

endmodule

// File: tb/tb_mc_control_unit.sv
module tb_mc_control_unit;

  localparam logic [3:0] S_FETCH  = 4'd0;
  localparam logic [3:0] S_DECODE = 4'd1;
  localparam logic [3:0] S_EXEC_R = 4'd2;
  localparam logic [3:0] S_EXEC_I = 4'd3;
  localparam logic [3:0] S_ADDR   = 4'd4;
  localparam logic [3:0] S_MEM_RD = 4'd5;
  localparam logic [3:0] S_WB_MEM = 4'd6;
  localparam logic [3:0] S_MEM_WR = 4'd7;
  localparam logic [3:0] S_WB_ALU = 4'd8;
  localparam logic [3:0] S_BRANCH = 4'd9;
  localparam logic [3:0] S_JUMP   = 4'd10;
  localparam logic [3:0] S_HALT   = 4'd11;

  // Field masks in the packed control vector
  localparam logic [17:0] B_PCW  = 18'h20000;
  localparam logic [17:0] B_PCWC = 18'h10000;
  localparam logic [17:0] B_IORD = 18'h08000;
  localparam logic [17:0] B_MRD  = 18'h04000;
  localparam logic [17:0] B_MWR  = 18'h02000;
  localparam logic [17:0] B_IRW  = 18'h01000;
  localparam logic [17:0] B_RDST = 18'h00800;
  localparam logic [17:0] B_M2R  = 18'h00400;
  localparam logic [17:0] B_RW   = 18'h00200;
  localparam logic [17:0] B_ASA  = 18'h00100;
  localparam logic [17:0] B_ASB  = 18'h000C0;
  localparam logic [17:0] B_AOP  = 18'h00038;
  localparam logic [17:0] B_PCS  = 18'h00006;
  localparam logic [17:0] B_HLT  = 18'h00001;
  localparam logic [17:0] STROBES = B_PCW | B_PCWC | B_MRD | B_MWR | B_IRW | B_RW | B_HLT;

  logic        clk = 1'b0;
  logic        rst_n, zero, mem_ready;
  logic [3:0]  opcode;
  logic [2:0]  funct;
  logic        pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic        reg_dst, mem_to_reg, reg_write, alu_src_a, halted;
  logic [1:0]  alu_src_b, pc_src;
  logic [2:0]  alu_op;
  logic [3:0]  state;
  logic [15:0] instr_count;

  int n_checks = 0;
  int n_fail   = 0;

  mc_control_unit dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
    .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write),
    .ir_write(ir_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .pc_src(pc_src), .state(state), .halted(halted),
    .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected control outputs for state st, from the specification table,
  // using the bench's own input values.
  task automatic check_ctrl(input string tag, input logic [3:0] st);
    logic e_pcw, e_pcwc, e_iord, e_mrd, e_mwr, e_irw, e_rdst, e_m2r, e_rw, e_asa, e_hlt;
    logic [1:0] e_asb, e_pcs;
    logic [2:0] e_aop;
    logic [17:0] mask, exp_v, obs_v;
    {e_pcw, e_pcwc, e_iord, e_mrd, e_mwr, e_irw, e_rdst, e_m2r, e_rw, e_asa, e_hlt} = 11'd0;
    e_asb = 2'b00; e_pcs = 2'b00; e_aop = 3'b000;
    mask = STROBES;
    case (st)
      S_FETCH: begin
        e_mrd = 1'b1; e_asb = 2'b01;
        e_irw = mem_ready & rst_n; e_pcw = mem_ready & rst_n;
        mask = mask | B_IORD | B_ASA | B_ASB | B_AOP | B_PCS;
      end
      S_DECODE: begin e_asb = 2'b10; mask = mask | B_ASA | B_ASB | B_AOP; end
      S_EXEC_R: begin e_asa = 1'b1; e_aop = funct; mask = mask | B_ASA | B_ASB | B_AOP; end
      S_EXEC_I, S_ADDR: begin e_asa = 1'b1; e_asb = 2'b10; mask = mask | B_ASA | B_ASB | B_AOP; end
      S_WB_ALU: begin e_rw = 1'b1; e_rdst = (opcode == 4'b0000); mask = mask | B_M2R | B_RDST; end
      S_MEM_RD: begin e_mrd = 1'b1; e_iord = 1'b1; mask = mask | B_IORD; end
      S_WB_MEM: begin e_rw = 1'b1; e_m2r = 1'b1; mask = mask | B_M2R | B_RDST; end
      S_MEM_WR: begin e_mwr = 1'b1; e_iord = 1'b1; mask = mask | B_IORD; end
      S_BRANCH: begin
        e_asa = 1'b1; e_aop = 3'b001; e_pcwc = 1'b1; e_pcs = 2'b01;
        mask = mask | B_ASA | B_ASB | B_AOP | B_PCS;
      end
      S_JUMP: begin e_pcw = 1'b1; e_pcs = 2'b10; mask = mask | B_PCS; end
      default: e_hlt = 1'b1;
    endcase
    exp_v = {e_pcw, e_pcwc, e_iord, e_mrd, e_mwr, e_irw, e_rdst, e_m2r, e_rw, e_asa, e_asb, e_aop, e_pcs, e_hlt};
    obs_v = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, reg_dst,
             mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op, pc_src, halted};
    check_eq({tag, "_state"}, {28'd0, state}, {28'd0, st});
    check_eq({tag, "_ctrl"}, {14'd0, obs_v & mask}, {14'd0, exp_v & mask});
  endtask

  // Check the current cycle (inputs already applied), then advance one clock.
  task automatic cyc(input string tag, input logic [3:0] st);
    #1;
    check_ctrl(tag, st);
    @(negedge clk);
  endtask

  task automatic check_cnt(input string tag, input logic [15:0] exp);
    check_eq(tag, {16'd0, instr_count}, {16'd0, exp});
  endtask

  initial begin
    rst_n = 1'b0; opcode = 4'b0000; funct = 3'b000; zero = 1'b0; mem_ready = 1'b1;

    // Reset: FETCH decode with ir_write/pc_write held low although mem_ready=1
    @(negedge clk);
    #1;
    check_ctrl("rst", S_FETCH);
    check_cnt("rst_cnt", 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;

    // R-type add: 0,1,2,8
    cyc("radd_f", S_FETCH); cyc("radd_d", S_DECODE); cyc("radd_x", S_EXEC_R); cyc("radd_wb", S_WB_ALU);
    check_cnt("radd_cnt", 16'd1);

    // ADDI: 0,1,3,8 with reg_dst=0
    opcode = 4'b0001;
    cyc("addi_f", S_FETCH); cyc("addi_d", S_DECODE); cyc("addi_x", S_EXEC_I); cyc("addi_wb", S_WB_ALU);
    check_cnt("addi_cnt", 16'd2);

    // R-type slt
    opcode = 4'b0000; funct = 3'b100;
    cyc("slt_f", S_FETCH); cyc("slt_d", S_DECODE); cyc("slt_x", S_EXEC_R); cyc("slt_wb", S_WB_ALU);
    check_cnt("slt_cnt", 16'd3);

    // LW: mem_ready low in DECODE/ADDR (ignored) and two MEM_RD cycles -> 7 cycles
    opcode = 4'b0010; funct = 3'b000;
    cyc("lw_f", S_FETCH);
    mem_ready = 1'b0;
    cyc("lw_d", S_DECODE); cyc("lw_a", S_ADDR);
    cyc("lw_rd0", S_MEM_RD); cyc("lw_rd1", S_MEM_RD);
    check_cnt("lw_cnt_mid", 16'd3);
    mem_ready = 1'b1;
    cyc("lw_rd2", S_MEM_RD); cyc("lw_wb", S_WB_MEM);
    check_eq("lw_back_fetch", {28'd0, state}, {28'd0, S_FETCH});
    check_cnt("lw_cnt", 16'd4);

    // SW: 0,1,4,7
    opcode = 4'b0011;
    cyc("sw_f", S_FETCH); cyc("sw_d", S_DECODE); cyc("sw_a", S_ADDR); cyc("sw_wr", S_MEM_WR);
    check_cnt("sw_cnt", 16'd5);

    // BEQ with zero low and high: BRANCH outputs do not depend on zero
    opcode = 4'b0100; zero = 1'b0;
    cyc("beq0_f", S_FETCH); cyc("beq0_d", S_DECODE); cyc("beq0_b", S_BRANCH);
    zero = 1'b1;
    cyc("beq1_f", S_FETCH); cyc("beq1_d", S_DECODE); cyc("beq1_b", S_BRANCH);
    check_cnt("beq_cnt", 16'd7);

    // J
    opcode = 4'b0101; zero = 1'b0;
    cyc("j_f", S_FETCH); cyc("j_d", S_DECODE); cyc("j_j", S_JUMP);
    check_cnt("j_cnt", 16'd8);

    // FETCH waits three cycles on mem_ready
    mem_ready = 1'b0;
    cyc("fw_0", S_FETCH); cyc("fw_1", S_FETCH); cyc("fw_2", S_FETCH);
    mem_ready = 1'b1;
    cyc("fw_rdy", S_FETCH); cyc("fw_d", S_DECODE); cyc("fw_j", S_JUMP);
    check_cnt("fw_cnt", 16'd9);

    // Illegal opcode 1111 -> HALT for 20 cycles, mem_ready toggling
    opcode = 4'b1111;
    cyc("ill_f", S_FETCH); cyc("ill_d", S_DECODE);
    for (int i = 0; i < 20; i++) begin
      mem_ready = i[0];
      cyc("ill_halt", S_HALT);
    end
    check_cnt("ill_cnt_frozen", 16'd9);
    // Asynchronous reset pulse mid-cycle
    #3 rst_n = 1'b0;
    #1;
    check_eq("ill_rst_halted", {31'd0, halted}, 32'd0);
    check_ctrl("ill_rst", S_FETCH);
    check_cnt("ill_rst_cnt", 16'd0);
    @(negedge clk);
    rst_n = 1'b1; mem_ready = 1'b1;

    // R-type with illegal funct 110 -> HALT
    opcode = 4'b0000; funct = 3'b110;
    cyc("badf_f", S_FETCH); cyc("badf_d", S_DECODE);
    for (int i = 0; i < 5; i++) begin
      cyc("badf_halt", S_HALT);
    end
    check_cnt("badf_cnt", 16'd0);
    #3 rst_n = 1'b0;
    #1;
    check_ctrl("badf_rst", S_FETCH);
    @(negedge clk);
    rst_n = 1'b1; funct = 3'b000;

    // Counter wrap: retire one J, preload near the top, retire two more
    opcode = 4'b0101;
    cyc("w0_f", S_FETCH); cyc("w0_d", S_DECODE); cyc("w0_j", S_JUMP);
    check_cnt("w0_cnt", 16'd1);
    dut.instr_count_r = 16'hFFFE;
    cyc("w1_f", S_FETCH); cyc("w1_d", S_DECODE); cyc("w1_j", S_JUMP);
    check_cnt("wrap_ffff", 16'hFFFF);
    cyc("w2_f", S_FETCH); cyc("w2_d", S_DECODE); cyc("w2_j", S_JUMP);
    check_cnt("wrap_0000", 16'h0000);

    // Reset in the middle of a stalled MEM_WR
    opcode = 4'b0011;
    cyc("swr_f", S_FETCH);
    mem_ready = 1'b0;
    cyc("swr_d", S_DECODE); cyc("swr_a", S_ADDR); cyc("swr_w0", S_MEM_WR); cyc("swr_w1", S_MEM_WR);
    #3 rst_n = 1'b0;
    #1;
    check_eq("swr_rst_mwr", {31'd0, mem_write}, 32'd0);
    check_ctrl("swr_rst", S_FETCH);
    check_cnt("swr_rst_cnt", 16'd0);
    @(negedge clk);
    rst_n = 1'b1; mem_ready = 1'b1;

    // Restart cleanly with an R-type sub
    opcode = 4'b0000; funct = 3'b001;
    cyc("rsub_f", S_FETCH); cyc("rsub_d", S_DECODE); cyc("rsub_x", S_EXEC_R); cyc("rsub_wb", S_WB_ALU);
    check_cnt("rsub_cnt", 16'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
